sub_serial: RTL

Bit-serial subtractor that computes A − B − Bin one bit per clock, LSB first, with a start/done handshake. It is the sequential subtract-direction counterpart to the team's combinational ripple adder (add4). It is used where area matters more than latency, and it feeds the same 4-bit datapath. Operands are captured on start, and the result is presented on Diff/Bout together with a one-cycle done pulse.

---
 rtl/sub_serial.sv | 92 +++++++++
 1 files changed

// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor computing A - B - Bin LSB first, one bit per clock,
// with a start/busy/done handshake and registered Diff/Bout.
module sub_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, d_sr_q, d_sr_d, diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d, bout_q, bout_d;
    logic             bit_d, br_nx;
    logic [WIDTH-1:0] d_shift;

    assign bit_d   = a_sr_q[0] ^ b_sr_q[0] ^ br_q;
    // borrow when a<b, or when the bits match and a borrow is already pending
    assign br_nx   = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & br_q);
    assign d_shift = {bit_d, d_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            IDLE: if (start) begin
                a_sr_d  = A;
                b_sr_d  = B;
                br_d    = Bin;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = d_shift;
                br_d   = br_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d  = d_shift;
                    bout_d  = br_nx;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign Diff = diff_q;
    assign Bout = bout_q;
endmodule
